multi_lifo_controller: RTL
==========================

MULTI_LIFO_CONTROLLER -- requirements
Module: multi_lifo_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, entries per stack; power of two, >= 2.
REQ-003 The block SHALL have parameter CHANNELS, default 4, number of independent stacks; >= 2.
REQ-004 The block SHALL have derived parameters DEPTH_LOG2 = CLOG2(DEPTH) and CHANNEL_LOG2 = CLOG2(CHANNELS); ADDR = CHANNEL_LOG2+DEPTH_LOG2.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high: clock  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-006 The block SHALL have the following ports:
- write_enable  in  1  push request.
- write_channel  in  CHANNEL_LOG2  push target stack.
- write_data  in  WIDTH  push data.
- read_enable  in  1  pop request.
- read_channel  in  CHANNEL_LOG2  pop/peek stack.
- read_data  out  WIDTH  top of read_channel stack.
- flush  in  CHANNELS  per-channel empty request.
- full  out  CHANNELS  per-channel full.
- empty  out  CHANNELS  per-channel empty.
- level  out  CHANNELS*(DEPTH_LOG2+1)  per-channel occupancy, channel c at bits [c*(DEPTH_LOG2+1) +: DEPTH_LOG2+1].
- overflow  out  1  pulse, push was dropped because the stack was full.
- underflow  out  1  pulse, pop was dropped because the stack was empty.
- memory_clock  out  1  equals clock.
- memory_write_enable  out  1  memory write strobe.
- memory_write_address  out  ADDR  memory write address.
- memory_write_data  out  WIDTH  memory write data.
- memory_read_enable  out  1  memory read strobe.
- memory_read_address  out  ADDR  memory read address.
- memory_read_data  in  WIDTH  combinational memory read data.

Function
REQ-007 The block SHALL keep one pointer per channel, DEPTH_LOG2+1 bits wide; level[c] = pointer[c], full[c] = (pointer[c]==DEPTH), empty[c] = (pointer[c]==0), all combinational from the pointers.
REQ-008 Channel c SHALL occupy memory addresses {c, index} (channel in the MSBs, index 0..DEPTH-1); index = pointer-1 is the top of stack.
REQ-009 A push (write_enable, channel w not full, flush[w]=0) SHALL write write_data to {w, pointer[w]} and increment pointer[w] at the next edge.
REQ-010 A pop (read_enable, channel r not empty, flush[r]=0) SHALL decrement pointer[r] at the next edge.
REQ-011 A push and a pop on the same channel in the same cycle, with the channel not empty, SHALL write to {c, pointer-1} (replace top), leave the pointer unchanged and raise no error; this also applies when the channel is full.
REQ-012 A push and a pop on the same channel in the same cycle, with the channel empty, SHALL perform the push only and raise underflow.
REQ-013 A push and a pop on different channels in the same cycle SHALL both take effect independently.
REQ-014 A push to a full channel (without a same-channel pop) SHALL be dropped: memory_write_enable=0, pointer unchanged, overflow=1 in the next cycle for exactly one cycle.
REQ-015 A pop from an empty channel SHALL be dropped with the pointer unchanged and underflow=1 in the next cycle for exactly one cycle.
REQ-016 flush[c]=1 SHALL set pointer[c] to 0 at the next edge; it takes priority over a push or pop to channel c in the same cycle, which is ignored silently: no memory write, no error pulse.
REQ-017 memory_write_enable SHALL be 1 only for an accepted push or replace; memory_write_data = write_data.
REQ-018 memory_read_address SHALL be {read_channel, pointer[read_channel]-1} (low DEPTH_LOG2 bits of the index); memory_read_enable = !empty[read_channel]; read_data = memory_read_data combinationally (zero-latency peek).
REQ-019 read_data SHALL be don't-care while empty[read_channel]=1.
REQ-020 overflow and underflow SHALL be registered, and depend only on the requests and state of the previous cycle.

Reset
REQ-021 While reset=1 at a clock edge, all pointers SHALL be 0 (empty=all ones, full=0, level=0) and overflow=underflow=0 from the following cycle onward.
REQ-022 Reset SHALL take priority over all requests, including requests in the same cycle; memory contents are not cleared and are considered invalid.
REQ-023 A push pending in the reset cycle SHALL not be counted.

Verification
REQ-024 Push 0x11, 0x22, 0x33 to channel 1, then pop three times -> read_data is 0x33, 0x22, 0x11; empty[1]=1 at the end; other channels remain at level 0.
REQ-025 With DEPTH=4: fill channel 2, then push 0x55 -> full[2]=1, no memory write, a one-cycle overflow pulse, level[2]=4.
REQ-026 Channel 0 holds 0xA0: push 0xB0 and pop on channel 0 simultaneously -> level stays 1, read_data=0xB0, no error; then the same on empty channel 3 -> level[3]=1, underflow pulse.
REQ-027 Push to channel 0 while popping channel 1 (level 2) in the same cycle -> level[0]+1, level[1]-1, and both tops correct.
REQ-028 Flush channel 1 (level 3) while pushing to channel 1 -> level[1]=0, no write, no error; assert reset with all channels non-empty -> all empty and levels 0 in the next cycle.

Source files
------------

// File: rtl/multi_lifo_controller.sv
// multi_lifo_controller
//   Manages CHANNELS independent LIFO stacks of DEPTH words each, all held in
//   one external memory. Channel c owns memory addresses {c, index}. Each
//   stack has a pointer (0..DEPTH) whose value is also the stack occupancy.
//
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   write_enable/channel/data : push request, target stack and data
//   read_enable/channel   : pop request; read_channel also selects the peek
//   read_data             : top of read_channel stack (zero-latency peek)
//   flush                 : per-channel empty request
//   full, empty, level    : per-channel status, decoded from the pointers
//   overflow, underflow   : one-cycle pulses for a dropped push or pop
//   memory_*              : external memory port; memory_read_data is
//                           combinational
module multi_lifo_controller #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int CHANNELS     = 4,
    parameter int DEPTH_LOG2   = $clog2(DEPTH),
    parameter int CHANNEL_LOG2 = $clog2(CHANNELS),
    parameter int ADDR         = CHANNEL_LOG2 + DEPTH_LOG2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               write_enable,
    input  logic [CHANNEL_LOG2-1:0]            write_channel,
    input  logic [WIDTH-1:0]                   write_data,
    input  logic                               read_enable,
    input  logic [CHANNEL_LOG2-1:0]            read_channel,
    output logic [WIDTH-1:0]                   read_data,
    input  logic [CHANNELS-1:0]                flush,
    output logic [CHANNELS-1:0]                full,
    output logic [CHANNELS-1:0]                empty,
    output logic [CHANNELS*(DEPTH_LOG2+1)-1:0] level,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               memory_clock,
    output logic                               memory_write_enable,
    output logic [ADDR-1:0]                    memory_write_address,
    output logic [WIDTH-1:0]                   memory_write_data,
    output logic                               memory_read_enable,
    output logic [ADDR-1:0]                    memory_read_address,
    input  logic [WIDTH-1:0]                   memory_read_data
);

    localparam int PW = DEPTH_LOG2 + 1;

    logic [PW-1:0] pointer [CHANNELS];

    logic [PW-1:0] wr_ptr, wr_ptr_m1, rd_ptr, rd_ptr_m1;
    logic          wr_full, wr_empty, rd_empty, same_channel;
    logic          wr_req, rd_req, replace, push_ok, pop_ok;
    logic          overflow_d, underflow_d;

    always_comb begin
        full  = '0;
        empty = '0;
        level = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            full[c]            = (pointer[c] == PW'(DEPTH));
            empty[c]           = (pointer[c] == '0);
            level[c*PW +: PW]  = pointer[c];
        end
    end

    always_comb begin
        wr_ptr       = pointer[write_channel];
        rd_ptr       = pointer[read_channel];
        wr_ptr_m1    = wr_ptr - PW'(1);
        rd_ptr_m1    = rd_ptr - PW'(1);
        wr_full      = full[write_channel];
        wr_empty     = empty[write_channel];
        rd_empty     = empty[read_channel];
        same_channel = (write_channel == read_channel);

        // A flushed channel silently ignores its requests.
        wr_req = write_enable && !flush[write_channel];
        rd_req = read_enable  && !flush[read_channel];

        // Same-channel push+pop on a non-empty stack overwrites the top in
        // place; a full stack is non-empty, so this also rescues that push.
        replace = wr_req && rd_req && same_channel && !wr_empty;
        push_ok = wr_req && !replace && !wr_full;
        pop_ok  = rd_req && !replace && !rd_empty;

        overflow_d  = wr_req && !replace && wr_full;
        underflow_d = rd_req && rd_empty;
    end

    assign memory_clock         = clock;
    assign memory_write_enable  = (push_ok || replace) && !reset;
    assign memory_write_address = {write_channel,
                                   replace ? wr_ptr_m1[DEPTH_LOG2-1:0]
                                           : wr_ptr[DEPTH_LOG2-1:0]};
    assign memory_write_data    = write_data;
    assign memory_read_enable   = !rd_empty;
    assign memory_read_address  = {read_channel, rd_ptr_m1[DEPTH_LOG2-1:0]};
    assign read_data            = memory_read_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                pointer[c] <= '0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_d;
            underflow <= underflow_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (flush[c]) begin
                    pointer[c] <= '0;
                end else if (push_ok && write_channel == CHANNEL_LOG2'(c)) begin
                    pointer[c] <= pointer[c] + PW'(1);
                end else if (pop_ok && read_channel == CHANNEL_LOG2'(c)) begin
                    pointer[c] <= pointer[c] - PW'(1);
                end
            end
        end
    end

endmodule
